// File: rtl/shadowed_register_bank.sv
// Bank of configuration registers with shadow copies that are committed atomically
// at a consumer-signalled safe point. Immediate registers bypass the shadow.
module shadowed_register_bank #(
    parameter int unsigned                       ADDR_WIDTH     = 16,
    parameter int unsigned                       DATA_WIDTH     = 16,
    parameter int unsigned                       N_REGS         = 4,
    parameter logic [ADDR_WIDTH-1:0]             BASE_ADDR      = 16'h0010,
    parameter logic [ADDR_WIDTH-1:0]             COMMIT_ADDR    = 16'h001F,
    parameter logic [N_REGS*DATA_WIDTH-1:0]      RESET_VALUES   = '0,
    parameter logic [N_REGS-1:0]                 IMMEDIATE_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        si_addr,
    input  logic [DATA_WIDTH-1:0]        si_data,
    input  logic                         si_rdy,
    output logic                         si_ack,
    input  logic                         apply_safe,
    output logic [N_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic [N_REGS-1:0]            updated,
    output logic [N_REGS-1:0]            dirty,
    output logic                         pending
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e                             state_q;
    logic [N_REGS-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic [N_REGS-1:0][DATA_WIDTH-1:0]  active_q, active_d;
    logic [N_REGS-1:0]                  dirty_q, dirty_d;
    logic [N_REGS-1:0]                  updated_q, updated_d;

    logic [N_REGS-1:0] hit_reg;
    logic [N_REGS-1:0] wr_reg;
    logic              hit_commit;
    logic              commit_wr;
    logic              do_apply;

    if (N_REGS < 1) begin : g_bad_nregs
        $error("shadowed_register_bank: N_REGS must be at least 1");
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_decode
        localparam logic [ADDR_WIDTH-1:0] RegAddr = ADDR_WIDTH'(BASE_ADDR + i);

        if (RegAddr == COMMIT_ADDR) begin : g_bad_commit
            $error("shadowed_register_bank: COMMIT_ADDR overlaps the register window");
        end

        assign hit_reg[i] = (si_addr == RegAddr);
    end

    assign hit_commit = (si_addr == COMMIT_ADDR);
    assign si_ack     = si_rdy & ((|hit_reg) | hit_commit);
    assign wr_reg     = {N_REGS{si_rdy}} & hit_reg;
    assign commit_wr  = si_rdy & hit_commit;
    assign do_apply   = (state_q == StPending) & apply_safe;

    // The apply is evaluated before the write, so a write on the apply edge leaves the
    // pre-write shadow value in the active copy and re-marks the register dirty.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        dirty_d   = dirty_q;
        updated_d = '0;

        if (do_apply) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                if (dirty_q[i]) begin
                    active_d[i] = shadow_q[i];
                end
            end
            updated_d = dirty_q;
            dirty_d   = '0;
        end

        for (int i = 0; i < int'(N_REGS); i++) begin
            if (wr_reg[i]) begin
                if (IMMEDIATE_MASK[i]) begin
                    active_d[i]  = si_data;
                    updated_d[i] = 1'b1;
                end else begin
                    shadow_d[i] = si_data;
                    dirty_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shadow_q  <= RESET_VALUES;
            active_q  <= RESET_VALUES;
            dirty_q   <= '0;
            updated_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (commit_wr) begin
                        state_q <= StPending;
                    end
                end
                StPending: begin
                    if (apply_safe) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            dirty_q   <= dirty_d;
            updated_q <= updated_d;
        end
    end

    assign regs_flat = active_q;
    assign updated   = updated_q;
    assign dirty     = dirty_q;
    assign pending   = (state_q == StPending);

endmodule
